// File: rtl/dmem_arbiter.sv
// Two-requester (core / host) arbiter for a single-ported data memory.
// Zero-latency combinational grants, lockable ownership, round-robin priority and a one-cycle read-return tag.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              c_req_i,
  input  logic              c_we_i,
  input  logic              c_lock_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic [DATA_W-1:0] c_wdata_i,
  output logic              c_gnt_o,
  output logic              c_rvalid_o,
  output logic [DATA_W-1:0] c_rdata_o,
  input  logic              h_req_i,
  input  logic              h_we_i,
  input  logic              h_lock_i,
  input  logic [ADDR_W-1:0] h_addr_i,
  input  logic [DATA_W-1:0] h_wdata_i,
  output logic              h_gnt_o,
  output logic              h_rvalid_o,
  output logic [DATA_W-1:0] h_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              c_stall_o
);

  localparam logic [1:0] OWN_FREE = 2'd0;
  localparam logic [1:0] OWN_CORE = 2'd1;
  localparam logic [1:0] OWN_HOST = 2'd2;

  logic [1:0] r_owner;
  logic       r_prio;
  logic       r_tagValid;
  logic       r_tagSrc;
  logic       w_cGnt;
  logic       w_hGnt;

  // The unused owner encoding falls into the FREE branch so it can never wedge the bus.
  always_comb begin
    w_cGnt = 1'b0;
    w_hGnt = 1'b0;
    if (!reset_i) begin
      case (r_owner)
        OWN_CORE: w_cGnt = c_req_i;
        OWN_HOST: w_hGnt = h_req_i;
        default: begin
          if (c_req_i && h_req_i) begin
            w_cGnt = ~r_prio;
            w_hGnt = r_prio;
          end else begin
            w_cGnt = c_req_i;
            w_hGnt = h_req_i;
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_cGnt) begin
      mem_we_o    = c_we_i;
      mem_addr_o  = c_addr_i;
      mem_wdata_o = c_wdata_i;
    end else if (w_hGnt) begin
      mem_we_o    = h_we_i;
      mem_addr_o  = h_addr_i;
      mem_wdata_o = h_wdata_i;
    end
  end

  assign c_gnt_o   = w_cGnt;
  assign h_gnt_o   = w_hGnt;
  assign mem_en_o  = w_cGnt | w_hGnt;
  assign c_stall_o = c_req_i & ~w_cGnt;

  // Ownership is only taken through a real grant, so a lone lock_i never claims the bus.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_owner    <= OWN_FREE;
      r_prio     <= 1'b0;
      r_tagValid <= 1'b0;
      r_tagSrc   <= 1'b0;
    end else begin
      case (r_owner)
        OWN_CORE: if (!c_lock_i) r_owner <= OWN_FREE;
        OWN_HOST: if (!h_lock_i) r_owner <= OWN_FREE;
        default: begin
          if (w_cGnt && c_lock_i)      r_owner <= OWN_CORE;
          else if (w_hGnt && h_lock_i) r_owner <= OWN_HOST;
          else                         r_owner <= OWN_FREE;
        end
      endcase
      if (w_cGnt)      r_prio <= 1'b1;
      else if (w_hGnt) r_prio <= 1'b0;
      r_tagValid <= mem_en_o & ~mem_we_o;
      r_tagSrc   <= w_hGnt;
    end
  end

  assign c_rvalid_o = r_tagValid & ~r_tagSrc;
  assign h_rvalid_o = r_tagValid & r_tagSrc;
  assign c_rdata_o  = c_rvalid_o ? mem_rdata_i : '0;
  assign h_rdata_o  = h_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a vector table of requests with hand-derived expected grants,
// and a read-return scoreboard fed at grant time and drained one cycle later.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          c_req_i, c_we_i, c_lock_i;
  logic [AW-1:0] c_addr_i;
  logic [DW-1:0] c_wdata_i;
  logic          c_gnt_o, c_rvalid_o;
  logic [DW-1:0] c_rdata_o;
  logic          h_req_i, h_we_i, h_lock_i;
  logic [AW-1:0] h_addr_i;
  logic [DW-1:0] h_wdata_i;
  logic          h_gnt_o, h_rvalid_o;
  logic [DW-1:0] h_rdata_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          c_stall_o;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .c_req_i(c_req_i), .c_we_i(c_we_i), .c_lock_i(c_lock_i), .c_addr_i(c_addr_i), .c_wdata_i(c_wdata_i),
    .c_gnt_o(c_gnt_o), .c_rvalid_o(c_rvalid_o), .c_rdata_o(c_rdata_o),
    .h_req_i(h_req_i), .h_we_i(h_we_i), .h_lock_i(h_lock_i), .h_addr_i(h_addr_i), .h_wdata_i(h_wdata_i),
    .h_gnt_o(h_gnt_o), .h_rvalid_o(h_rvalid_o), .h_rdata_o(h_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .c_stall_o(c_stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          cReq, cWe, cLock;
    logic [AW-1:0] cAddr;
    logic [DW-1:0] cWdata;
    logic          hReq, hWe, hLock;
    logic [AW-1:0] hAddr;
    logic [DW-1:0] hWdata;
    logic          expC, expH;
  } vec_t;

  typedef struct {
    logic valid;
    logic src;
  } tag_t;

  tag_t          sb[$];
  int            testsRun = 0;
  int            testsFailed = 0;
  logic [DW-1:0] memData;
  vec_t          tbl[23];

  function automatic vec_t mk(logic cr, logic cw, logic cl, logic [AW-1:0] ca, logic [DW-1:0] cd,
                              logic hr, logic hw, logic hl, logic [AW-1:0] ha, logic [DW-1:0] hd,
                              logic ec, logic eh);
    vec_t v;
    v.cReq = cr; v.cWe = cw; v.cLock = cl; v.cAddr = ca; v.cWdata = cd;
    v.hReq = hr; v.hWe = hw; v.hLock = hl; v.hAddr = ha; v.hWdata = hd;
    v.expC = ec; v.expH = eh;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk_i);
    c_req_i = v.cReq; c_we_i = v.cWe; c_lock_i = v.cLock; c_addr_i = v.cAddr; c_wdata_i = v.cWdata;
    h_req_i = v.hReq; h_we_i = v.hWe; h_lock_i = v.hLock; h_addr_i = v.hAddr; h_wdata_i = v.hWdata;
    memData = $urandom;
    mem_rdata_i = memData;
  endtask

  task automatic checkOutput(input vec_t v, input string name);
    logic          expWe;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWdata;
    tag_t          t;
    #1;
    expWe = 1'b0; expAddr = '0; expWdata = '0;
    if (v.expC) begin
      expWe = v.cWe; expAddr = v.cAddr; expWdata = v.cWdata;
    end else if (v.expH) begin
      expWe = v.hWe; expAddr = v.hAddr; expWdata = v.hWdata;
    end
    check({name, "_c_gnt"},     64'(c_gnt_o),     64'(v.expC));
    check({name, "_h_gnt"},     64'(h_gnt_o),     64'(v.expH));
    check({name, "_mem_en"},    64'(mem_en_o),    64'(v.expC | v.expH));
    check({name, "_mem_we"},    64'(mem_we_o),    64'(expWe));
    check({name, "_mem_addr"},  64'(mem_addr_o),  64'(expAddr));
    check({name, "_mem_wdata"}, 64'(mem_wdata_o), 64'(expWdata));
    check({name, "_c_stall"},   64'(c_stall_o),   64'(v.cReq & ~v.expC));
    if (sb.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s_scoreboard: got empty queue, expected one entry", name);
      t.valid = 1'b0;
      t.src   = 1'b0;
    end else begin
      t = sb.pop_front();
    end
    check({name, "_c_rvalid"}, 64'(c_rvalid_o), 64'(t.valid & ~t.src));
    check({name, "_h_rvalid"}, 64'(h_rvalid_o), 64'(t.valid & t.src));
    check({name, "_c_rdata"},  64'(c_rdata_o),  64'((t.valid && !t.src) ? memData : '0));
    check({name, "_h_rdata"},  64'(h_rdata_o),  64'((t.valid && t.src) ? memData : '0));
    t.valid = (v.expC && !v.cWe) || (v.expH && !v.hWe);
    t.src   = v.expH;
    sb.push_back(t);
  endtask

  task automatic runCycle(input vec_t v, input string name);
    applyStimulus(v);
    checkOutput(v, name);
  endtask

  // Reset is raised mid-cycle with both requests high: grants must vanish and any pending rvalid drop at once.
  task automatic doReset(input string name);
    tag_t t;
    @(negedge clk_i);
    c_req_i = 1'b1; h_req_i = 1'b1;
    reset_i = 1'b1;
    #1;
    check({name, "_rst_c_gnt"},    64'(c_gnt_o),    64'(0));
    check({name, "_rst_h_gnt"},    64'(h_gnt_o),    64'(0));
    check({name, "_rst_mem_en"},   64'(mem_en_o),   64'(0));
    check({name, "_rst_c_rvalid"}, 64'(c_rvalid_o), 64'(0));
    check({name, "_rst_h_rvalid"}, 64'(h_rvalid_o), 64'(0));
    @(negedge clk_i);
    reset_i = 1'b0;
    c_req_i = 1'b0; c_we_i = 1'b0; c_lock_i = 1'b0; c_addr_i = '0; c_wdata_i = '0;
    h_req_i = 1'b0; h_we_i = 1'b0; h_lock_i = 1'b0; h_addr_i = '0; h_wdata_i = '0;
    sb.delete();
    t.valid = 1'b0;
    t.src   = 1'b0;
    sb.push_back(t);
  endtask

  initial begin
    reset_i = 1'b1;
    c_req_i = 1'b0; c_we_i = 1'b0; c_lock_i = 1'b0; c_addr_i = '0; c_wdata_i = '0;
    h_req_i = 1'b0; h_we_i = 1'b0; h_lock_i = 1'b0; h_addr_i = '0; h_wdata_i = '0;
    mem_rdata_i = '0;
    memData = '0;

    //                cr cw cl cAddr   cWdata  hr hw hl hAddr   hWdata  gC gH
    tbl[0]  = mk(1, 0, 0, 32'h100, 32'h0,  1, 0, 0, 32'h200, 32'h0, 1, 0);
    tbl[1]  = mk(1, 0, 0, 32'h100, 32'h0,  1, 0, 0, 32'h200, 32'h0, 0, 1);
    tbl[2]  = mk(1, 0, 0, 32'h104, 32'h0,  1, 0, 0, 32'h200, 32'h0, 1, 0);
    tbl[3]  = mk(1, 0, 0, 32'h108, 32'h0,  1, 0, 0, 32'h204, 32'h0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 32'h0,   32'h0,  0, 0, 0, 32'h0,   32'h0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 32'h10,  32'h0,  0, 0, 0, 32'h0,   32'h0, 1, 0);
    tbl[6]  = mk(0, 0, 0, 32'h0,   32'h0,  0, 0, 0, 32'h0,   32'h0, 0, 0);
    tbl[7]  = mk(1, 1, 0, 32'h20,  32'h55, 0, 0, 0, 32'h0,   32'h0, 1, 0);
    tbl[8]  = mk(0, 0, 0, 32'h0,   32'h0,  1, 0, 0, 32'h20,  32'h0, 0, 1);
    tbl[9]  = mk(0, 0, 0, 32'h0,   32'h0,  0, 0, 0, 32'h0,   32'h0, 0, 0);
    tbl[10] = mk(0, 0, 1, 32'h0,   32'h0,  1, 0, 0, 32'h30,  32'h0, 0, 1);
    tbl[11] = mk(0, 0, 0, 32'h0,   32'h0,  1, 0, 0, 32'h34,  32'h0, 0, 1);
    tbl[12] = mk(1, 0, 0, 32'h50,  32'h0,  0, 0, 0, 32'h0,   32'h0, 1, 0);
    tbl[13] = mk(1, 0, 0, 32'h60,  32'h0,  1, 0, 1, 32'h70,  32'h0, 0, 1);
    tbl[14] = mk(1, 0, 0, 32'h60,  32'h0,  1, 0, 1, 32'h74,  32'h0, 0, 1);
    tbl[15] = mk(1, 0, 0, 32'h60,  32'h0,  1, 1, 1, 32'h78,  32'h77, 0, 1);
    tbl[16] = mk(1, 0, 0, 32'h60,  32'h0,  0, 0, 0, 32'h0,   32'h0, 0, 0);
    tbl[17] = mk(1, 0, 0, 32'h60,  32'h0,  0, 0, 0, 32'h0,   32'h0, 1, 0);
    tbl[18] = mk(1, 0, 1, 32'h80,  32'h0,  0, 0, 0, 32'h0,   32'h0, 1, 0);
    tbl[19] = mk(1, 1, 1, 32'h84,  32'hAB, 1, 0, 0, 32'h90,  32'h0, 1, 0);
    tbl[20] = mk(0, 0, 1, 32'h0,   32'h0,  1, 0, 0, 32'h90,  32'h0, 0, 0);
    tbl[21] = mk(0, 0, 0, 32'h0,   32'h0,  1, 0, 0, 32'h90,  32'h0, 0, 0);
    tbl[22] = mk(0, 0, 0, 32'h0,   32'h0,  1, 0, 0, 32'h90,  32'h0, 0, 1);

    doReset("init");
    for (int i = 0; i < 23; i++) runCycle(tbl[i], $sformatf("vec%0d", i));

    // Core lock with a read in flight, then reset: host alone must win immediately afterwards.
    doReset("seqA0");
    runCycle(mk(1, 0, 1, 32'h90, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0), "seqA_lockrd");
    doReset("seqA1");
    runCycle(mk(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'hA0, 32'h0, 0, 1), "seqA_host");
    runCycle(mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0), "seqA_idle");

    // Priority pointed at host before reset; after reset a tie must go to core again.
    runCycle(mk(1, 0, 0, 32'hB0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0), "seqB_core");
    doReset("seqB");
    runCycle(mk(1, 0, 0, 32'hB4, 32'h0, 1, 0, 0, 32'hC0, 32'h0, 1, 0), "seqB_tie");
    runCycle(mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0), "seqB_idle");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32: requester and memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 32: data width.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
 clk_i  in  1  single clock
 reset_i  in  1  asynchronous, active-high reset
 c_req_i  in  1  core request
 c_we_i  in  1  core write (1) / read (0)
 c_lock_i  in  1  core keeps ownership while high
 c_addr_i  in  ADDR_W  core address
 c_wdata_i  in  DATA_W  core write data
 c_gnt_o  out  1  core access accepted this cycle
 c_rvalid_o  out  1  core read data valid
 c_rdata_o  out  DATA_W  core read data
 h_req_i, h_we_i, h_lock_i, h_addr_i, h_wdata_i  in  same widths  host/debug requester, same meaning
 h_gnt_o, h_rvalid_o, h_rdata_o  out  same widths  host responses, same meaning
 mem_en_o  out  1  memory access strobe
 mem_we_o  out  1  memory write
 mem_addr_o  out  ADDR_W  memory address
 mem_wdata_o  out  DATA_W  memory write data
 mem_rdata_i  in  DATA_W  memory read data, valid one cycle after mem_en_o with mem_we_o=0
 c_stall_o  out  1  c_req_i & ~c_gnt_o, for core PC/pipeline hold

Function
REQ-004 The block SHALL arbitrate every cycle; grants SHALL be combinational from requests and registered state, with zero-cycle grant latency.
REQ-005 The block SHALL hold an owner register with states FREE, CORE, HOST, and a priority pointer prio_q (0=core first, 1=host first).
REQ-006 FREE: if exactly one req is high, that requester SHALL be granted; if both are high, the requester indicated by prio_q SHALL be granted.
REQ-007 CORE (or HOST): the owner SHALL be granted whenever its req is high; the other requester SHALL NOT be granted.
REQ-008 Transition: after a grant with that requester's lock_i=1, owner SHALL become that requester; when the owner's lock_i is low at a clock edge, owner SHALL return to FREE.
REQ-009 The lock state SHALL be sampled at the clock edge; lock_i without req_i SHALL NOT create ownership from FREE.
REQ-010 After any grant, prio_q SHALL point to the non-granted requester (round-robin); prio_q SHALL NOT change in cycles with no grant.
REQ-011 At most one gnt_o SHALL be high per cycle; mem_en_o SHALL equal c_gnt_o | h_gnt_o.
REQ-012 The mem_* outputs SHALL carry the granted requester's we/addr/wdata in the grant cycle; when no requester is granted, mem_en_o=0, mem_we_o=0, and addr/wdata SHALL be 0.
REQ-013 The block SHALL register a one-cycle read tag {valid, source} on a granted read.
REQ-014 In the next cycle, the tagged requester's rvalid_o SHALL be 1 and its rdata_o SHALL equal mem_rdata_i; the other rdata_o SHALL be 0.
REQ-015 Writes SHALL produce no rvalid.
REQ-016 Back-to-back grants SHALL be supported, with one access per cycle and rvalid pipelined behind each read grant.
REQ-017 A requester SHALL hold req/we/addr/wdata stable until it sees gnt; the block SHALL NOT buffer requests.
REQ-018 A non-owner with req held during a lock SHALL be granted in the first cycle owner is FREE, subject to REQ-006.

Reset
REQ-019 On reset_i=1 (asynchronous), the block SHALL set owner=FREE, prio_q=0, read tag invalid, and all rvalid_o=0.
REQ-020 Combinational outputs SHALL still follow REQ-006 from the reset state; while reset_i is high, all gnt_o and mem_en_o SHALL be forced to 0.
REQ-021 A reset asserted mid-lock or with a read in flight SHALL drop ownership and the pending rvalid.

Verification
REQ-022 Scenario, single core read: c_req=1, we=0, addr=0x10 -> c_gnt=1 and mem_addr=0x10 in the same cycle; next cycle, with mem_rdata=0xDEADBEEF, c_rvalid=1 and c_rdata=0xDEADBEEF.
REQ-023 Scenario, simultaneous requests after reset, both held for 4 cycles -> grants C, H, C, H.
REQ-024 Scenario, host lock: h_req=h_lock=1 for 3 cycles while c_req=1 -> h_gnt on 3 cycles, c_stall=1 throughout; c_gnt in the cycle after h_lock drops.
REQ-025 Scenario, write then read: c write 0x20<=0x55 followed by h read 0x20 -> mem_we=1 then 0, with no c_rvalid; h_rvalid exactly one cycle after the h_gnt.
REQ-026 Scenario, reset during core lock with a read in flight -> owner=FREE, no rvalid on the following cycle, prio_q=0.
